alu_seq: RTL

//  Issue/writeback sequencer that sits on the driving side of the 8-bit ALU (alu_ctrl, A, B -> alu_out, cy, zero).

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_regfile.sv | 38 +++
 rtl/alu_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: ALU op codes,
// special opcodes, FSM states and instruction field positions.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_NOT = 3'd5;
   localparam logic [2:0] ALU_SHR = 3'd6;
   localparam logic [2:0] ALU_SHL = 3'd7;

   localparam logic [3:0] OPC_LDI = 4'h8;
   localparam logic [3:0] OPC_NOP = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_EXEC  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned OPC_W   = 4;
   localparam int unsigned RD_LSB  = 10;
   localparam int unsigned RS1_LSB = 8;
   localparam int unsigned RS2_LSB = 0;
   localparam int unsigned REG_W   = 2;
   localparam int unsigned IMM_LSB = 0;
   localparam int unsigned IMM_W   = 8;

   // Opcodes 0..7 map directly onto an ALU operation.
   function automatic logic is_alu_op(input logic [3:0] opc);
      return !opc[3];
   endfunction

   function automatic logic is_illegal(input logic [3:0] opc);
      return opc[3] && (opc != OPC_LDI) && (opc != OPC_NOP);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Four-entry register file: one write port, operand read ports rs1/rs2 and a
// debug read port. All reads are combinational.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned     DW      = 8,
   parameter logic [DW-1:0]   REG_RST = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_W-1:0]  waddr,
   input  logic [DW-1:0]     wdata,
   input  logic [REG_W-1:0]  rs1_addr,
   output logic [DW-1:0]     rs1_data,
   input  logic [REG_W-1:0]  rs2_addr,
   output logic [DW-1:0]     rs2_data,
   input  logic [REG_W-1:0]  dbg_addr,
   output logic [DW-1:0]     dbg_data
);

   logic [DW-1:0] regs [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 4; i++) begin
            regs[i] <= REG_RST;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Execute-stage sequencer: accepts one instruction per handshake, drives the
// external ALU and writes its result and flags back into the register file.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned     DW      = 8,
   parameter logic [DW-1:0]   REG_RST = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [15:0]    instr,
   output logic [2:0]     alu_ctrl,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   input  logic [DW-1:0]  alu_out,
   input  logic           alu_cy,
   input  logic           alu_zero,
   output logic           done,
   output logic           err,
   output logic           flag_cy,
   output logic           flag_z,
   input  logic [1:0]     dbg_sel,
   output logic [DW-1:0]  dbg_data
);

   state_t                state, state_nxt;
   logic [INSTR_W-1:0]    instr_q;
   logic [OPC_W-1:0]      opc_q;
   logic [2:0]            op_q;
   logic                  accept;

   logic                  rf_we;
   logic [DW-1:0]         rf_wdata;
   logic [DW-1:0]         rs1_data, rs2_data;

   assign opc_q  = instr_q[OPC_LSB +: OPC_W];
   assign op_q   = opc_q[2:0];
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      rf_we     = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_SETUP;
         end
         S_SETUP: state_nxt = S_EXEC;
         S_EXEC: begin
            rf_we     = is_alu_op(opc_q) || (opc_q == OPC_LDI);
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            err       = is_illegal(opc_q);
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign rf_wdata = is_alu_op(opc_q) ? alu_out : DW'(instr_q[IMM_LSB +: IMM_W]);

   // The ALU only re-evaluates on an alu_ctrl change, so SETUP drives the
   // inverse op and EXEC the real one; back-to-back identical ops still
   // produce a fresh result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q  <= '0;
         alu_a    <= REG_RST;
         alu_b    <= REG_RST;
         alu_ctrl <= '0;
         flag_cy  <= 1'b0;
         flag_z   <= 1'b0;
      end else begin
         if (accept) begin
            instr_q  <= instr;
            alu_a    <= rs1_data;
            alu_b    <= rs2_data;
            alu_ctrl <= ~instr[OPC_LSB +: 3];
         end else if (state == S_SETUP) begin
            alu_ctrl <= op_q;
         end
         if ((state == S_EXEC) && is_alu_op(opc_q)) begin
            flag_cy <= alu_cy;
            flag_z  <= alu_zero;
         end
      end
   end

   alu_regfile #(
      .DW      (DW),
      .REG_RST (REG_RST)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (rf_we),
      .waddr    (instr_q[RD_LSB +: REG_W]),
      .wdata    (rf_wdata),
      .rs1_addr (instr[RS1_LSB +: REG_W]),
      .rs1_data (rs1_data),
      .rs2_addr (instr[RS2_LSB +: REG_W]),
      .rs2_data (rs2_data),
      .dbg_addr (dbg_sel),
      .dbg_data (dbg_data)
   );

endmodule
